// File: rtl/cache_ctrl_assoc.sv
// Set-associative write-back / write-allocate L1 cache controller, one CPU request in flight.
// Latency: hit -> done the cycle after accept; miss -> 2 cycles plus memory wait per transfer.
// Backpressure: ready is high only in IDLE; memory side holds mem_req until mem_ack.
module cache_ctrl_assoc #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int SETS   = 4,
  parameter int WAYS   = 2,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] data_in,
  input  logic              read_en,
  input  logic              write_en,
  output logic              ready,
  output logic              done,
  output logic [DATA_W-1:0] data_out,
  output logic              hit_flag,
  output logic [CNT_W-1:0]  hit_count,
  output logic [CNT_W-1:0]  miss_count,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int IDX_W  = $clog2(SETS);
  localparam int LINE_W = ADDR_W - 2;
  localparam int TAG_W  = LINE_W - IDX_W;

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_WRITEBACK, S_FILL, S_RESP
  } state_t;

  state_t state_q, state_d;

  // Accepted request; the byte-offset bits of the address carry no information.
  logic [LINE_W-1:0] req_line_q;
  logic [DATA_W-1:0] req_data_q;
  logic              req_we_q;
  logic              unused_addr_lsb;
  assign unused_addr_lsb = ^address[1:0];

  // Line state. Tag/data storage is not reset; valid gates every use of it.
  logic              valid_q [WAYS][SETS];
  logic              dirty_q [WAYS][SETS];
  logic [TAG_W-1:0]  tag_q   [WAYS][SETS];
  logic [DATA_W-1:0] data_q  [WAYS][SETS];
  logic              lru_q   [SETS];

  logic              victim_q;
  logic [DATA_W-1:0] fill_word_q;
  logic [DATA_W-1:0] data_out_q;
  logic              hit_flag_q;

  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  req_tag;
  logic              hit;
  logic              hit_way;
  logic              victim;
  logic [DATA_W-1:0] fill_val;

  assign idx      = req_line_q[IDX_W-1:0];
  assign req_tag  = req_line_q[LINE_W-1:IDX_W];
  assign fill_val = req_we_q ? req_data_q : mem_rdata;

  // Tag match across the ways of the indexed set, and victim choice (lowest invalid way, else LRU).
  always_comb begin
    hit     = 1'b0;
    hit_way = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[w][idx] && (tag_q[w][idx] == req_tag)) begin
        hit     = 1'b1;
        hit_way = w[0];
      end
    end
    victim = (WAYS == 1) ? 1'b0 : lru_q[idx];
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[w][idx]) victim = w[0];
    end
  end

  // Next-state and all control outputs; response data is presented combinationally on done, then held.
  always_comb begin
    state_d   = state_q;
    ready     = 1'b0;
    done      = 1'b0;
    data_out  = data_out_q;
    hit_flag  = hit_flag_q;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state_q)
      S_IDLE: begin
        ready = 1'b1;
        if (read_en || write_en) state_d = S_LOOKUP;
      end
      S_LOOKUP: begin
        if (hit) begin
          done     = 1'b1;
          hit_flag = 1'b1;
          data_out = req_we_q ? req_data_q : data_q[hit_way][idx];
          state_d  = S_IDLE;
        end else if (valid_q[victim][idx] && dirty_q[victim][idx]) begin
          state_d = S_WRITEBACK;
        end else begin
          state_d = S_FILL;
        end
      end
      S_WRITEBACK: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {tag_q[victim_q][idx], idx, 2'b00};
        mem_wdata = data_q[victim_q][idx];
        if (mem_ack) state_d = S_FILL;
      end
      S_FILL: begin
        mem_req  = 1'b1;
        mem_addr = {req_tag, idx, 2'b00};
        if (mem_ack) state_d = S_RESP;
      end
      S_RESP: begin
        done     = 1'b1;
        hit_flag = 1'b0;
        data_out = fill_word_q;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register, request capture, counters, and valid/dirty/LRU bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      req_line_q  <= '0;
      req_data_q  <= '0;
      req_we_q    <= 1'b0;
      victim_q    <= 1'b0;
      fill_word_q <= '0;
      data_out_q  <= '0;
      hit_flag_q  <= 1'b0;
      hit_count   <= '0;
      miss_count  <= '0;
      for (int s = 0; s < SETS; s++) begin
        lru_q[s] <= 1'b0;
        for (int w = 0; w < WAYS; w++) begin
          valid_q[w][s] <= 1'b0;
          dirty_q[w][s] <= 1'b0;
        end
      end
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && (read_en || write_en)) begin
        req_line_q <= address[ADDR_W-1:2];
        req_data_q <= data_in;
        req_we_q   <= write_en;
      end
      if (done) begin
        data_out_q <= data_out;
        hit_flag_q <= hit_flag;
      end
      case (state_q)
        S_LOOKUP: begin
          if (hit) begin
            if (hit_count != '1) hit_count <= hit_count + 1'b1;
            lru_q[idx] <= ~hit_way;
            if (req_we_q) dirty_q[hit_way][idx] <= 1'b1;
          end else begin
            if (miss_count != '1) miss_count <= miss_count + 1'b1;
            victim_q <= victim;
          end
        end
        S_FILL: begin
          if (mem_ack) begin
            valid_q[victim_q][idx] <= 1'b1;
            dirty_q[victim_q][idx] <= req_we_q;
            fill_word_q            <= fill_val;
          end
        end
        S_RESP: lru_q[idx] <= ~victim_q;
        default: ;
      endcase
    end
  end

  // Tag and data storage: write hits update the word, fills install tag and word.
  always_ff @(posedge clk) begin
    if (!reset && state_q == S_LOOKUP && hit && req_we_q) begin
      data_q[hit_way][idx] <= req_data_q;
    end
    if (!reset && state_q == S_FILL && mem_ack) begin
      tag_q[victim_q][idx]  <= req_tag;
      data_q[victim_q][idx] <= fill_val;
    end
  end

endmodule

// File: tb/tb_cache_ctrl_assoc.sv
// Directed bench for cache_ctrl_assoc with a responding memory model.
// Expected CPU responses and memory transfers are queued by stimulus, popped by monitors.
// Memory ack delay is programmable per scenario, including ack in the first request cycle.
module tb_cache_ctrl_assoc;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] address;
  logic [31:0] data_in;
  logic        read_en;
  logic        write_en;
  logic        ready;
  logic        done;
  logic [31:0] data_out;
  logic        hit_flag;
  logic [7:0]  hit_count;
  logic [7:0]  miss_count;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  cache_ctrl_assoc #(
    .ADDR_W(32), .DATA_W(32), .SETS(4), .WAYS(2), .CNT_W(8)
  ) dut (
    .clk(clk), .reset(reset), .address(address), .data_in(data_in),
    .read_en(read_en), .write_en(write_en), .ready(ready), .done(done),
    .data_out(data_out), .hit_flag(hit_flag), .hit_count(hit_count),
    .miss_count(miss_count), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] data;
    logic        hit;
  } rsp_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_t;

  rsp_t        exp_rsp [$];
  mem_t        exp_mem [$];
  logic [31:0] mem_model [logic [31:0]];
  int          ack_delay = 0;
  int          pass_cnt  = 0;
  int          total_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  task automatic expect_mem(input logic we, input logic [31:0] a, input logic [31:0] wd);
    mem_t m;
    m.we = we; m.addr = a; m.wdata = wd;
    exp_mem.push_back(m);
  endtask

  // Issue one request from a negedge; returns on the negedge after done.
  task automatic do_req(input logic re, input logic we, input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] exp_data, input logic exp_hit, input bit chk_lat);
    int   cyc;
    rsp_t r;
    cyc = 0;
    while (!ready && cyc < 200) begin @(negedge clk); cyc++; end
    if (!ready) check("ready_timeout", ready, 1);
    r.data = exp_data; r.hit = exp_hit;
    exp_rsp.push_back(r);
    read_en = re; write_en = we; address = a; data_in = d;
    @(negedge clk);
    read_en = 1'b0; write_en = 1'b0; address = $urandom; data_in = $urandom;
    if (chk_lat) check("hit_latency_done", done, 1);
    cyc = 0;
    while (!done && cyc < 200) begin @(negedge clk); cyc++; end
    if (!done) check("done_timeout", done, 1);
    @(negedge clk);
  endtask

  // Response monitor: every done must match the oldest expected response.
  initial begin
    rsp_t r;
    forever begin
      @(negedge clk);
      if (done) begin
        if (exp_rsp.size() == 0) check("unexpected_done", done, 0);
        else begin
          r = exp_rsp.pop_front();
          check("rsp_data", data_out, r.data);
          check("rsp_hit", hit_flag, r.hit);
        end
      end
    end
  end

  // Memory responder: checks each transfer against the expected queue, acks after ack_delay.
  initial begin
    logic [31:0] a, wd;
    logic        we;
    mem_t        m;
    mem_ack = 1'b0; mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (mem_req && !reset) begin
        a = mem_addr; we = mem_we; wd = mem_wdata;
        if (exp_mem.size() == 0) check("unexpected_mem_req", mem_req, 0);
        else begin
          m = exp_mem.pop_front();
          check("mem_we", we, m.we);
          check("mem_addr", a, m.addr);
          if (m.we) check("mem_wdata", wd, m.wdata);
        end
        for (int i = 0; i < ack_delay && mem_req; i++) @(negedge clk);
        if (mem_req) begin
          if (mem_we !== we || mem_addr !== a) check("mem_stable_addr", mem_addr, a);
          mem_ack   = 1'b1;
          mem_rdata = mem_model.exists(a) ? mem_model[a] : 32'h0;
          if (we) mem_model[a] = wd;
          @(negedge clk);
          mem_ack   = 1'b0;
          mem_rdata = $urandom;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got %0d checks done expected completion", total_cnt);
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    reset = 1'b1; read_en = 1'b0; write_en = 1'b0; address = '0; data_in = '0;
    mem_model[32'h00] = 32'h1111_0000;
    mem_model[32'h10] = 32'h2222_0000;
    mem_model[32'h20] = 32'h3333_0000;
    mem_model[32'h04] = 32'h4444_0000;
    repeat (3) @(negedge clk);
    check("rst_ready", ready, 1);
    check("rst_done", done, 0);
    check("rst_hit_flag", hit_flag, 0);
    check("rst_data_out", data_out, 0);
    check("rst_hit_count", hit_count, 0);
    check("rst_miss_count", miss_count, 0);
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_addr", mem_addr, 0);
    reset = 1'b0;
    @(negedge clk);

    // 1: cold miss, fill after 3 cycles
    ack_delay = 3;
    expect_mem(1'b0, 32'h00, 32'h0);
    do_req(1'b1, 1'b0, 32'h00, 32'h0, 32'h1111_0000, 1'b0, 1'b0);
    check("t1_miss_count", miss_count, 1);
    check("t1_hold_data_out", data_out, 32'h1111_0000);
    check("t1_hold_done_low", done, 0);

    // 2: hit, done the cycle after accept
    do_req(1'b1, 1'b0, 32'h00, 32'h0, 32'h1111_0000, 1'b1, 1'b1);
    check("t2_hit_count", hit_count, 1);

    // 3: write-allocate to way1, dirty eviction, refill of evicted line
    ack_delay = 1;
    expect_mem(1'b0, 32'h10, 32'h0);
    do_req(1'b0, 1'b1, 32'h10, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 1'b0, 1'b0);
    do_req(1'b1, 1'b0, 32'h00, 32'h0, 32'h1111_0000, 1'b1, 1'b1);
    ack_delay = 0;
    expect_mem(1'b1, 32'h10, 32'hA5A5_A5A5);
    expect_mem(1'b0, 32'h20, 32'h0);
    do_req(1'b1, 1'b0, 32'h20, 32'h0, 32'h3333_0000, 1'b0, 1'b0);
    ack_delay = 2;
    expect_mem(1'b0, 32'h10, 32'h0);
    do_req(1'b1, 1'b0, 32'h10, 32'h0, 32'hA5A5_A5A5, 1'b0, 1'b0);
    check("t3_hit_count", hit_count, 2);
    check("t3_miss_count", miss_count, 4);

    // 4: 0x00 was evicted by the last fill; re-fetch, then 300 hits saturate hit_count
    ack_delay = 1;
    expect_mem(1'b0, 32'h00, 32'h0);
    do_req(1'b1, 1'b0, 32'h00, 32'h0, 32'h1111_0000, 1'b0, 1'b0);
    for (int i = 0; i < 300; i++) do_req(1'b1, 1'b0, 32'h00, 32'h0, 32'h1111_0000, 1'b1, 1'b0);
    check("t4_hit_sat", hit_count, 255);
    check("t4_miss_count", miss_count, 5);

    // 5: reset while FILL waits for ack
    ack_delay = 20;
    expect_mem(1'b0, 32'h04, 32'h0);
    read_en = 1'b1; address = 32'h04;
    @(negedge clk);
    read_en = 1'b0;
    cyc = 0;
    while (!mem_req && cyc < 50) begin @(negedge clk); cyc++; end
    check("t5_mem_req_seen", mem_req, 1);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("t5_mem_req_drop", mem_req, 0);
    check("t5_hit_count", hit_count, 0);
    check("t5_miss_count", miss_count, 0);
    check("t5_ready", ready, 1);
    check("t5_hit_flag", hit_flag, 0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    ack_delay = 1;
    expect_mem(1'b0, 32'h00, 32'h0);
    do_req(1'b1, 1'b0, 32'h00, 32'h0, 32'h1111_0000, 1'b0, 1'b0);
    check("t5_miss_after_rst", miss_count, 1);

    // 6: read_en and write_en together is a write
    do_req(1'b1, 1'b1, 32'h00, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1, 1'b1);
    do_req(1'b1, 1'b0, 32'h00, 32'h0, 32'hDEAD_BEEF, 1'b1, 1'b1);
    check("t6_hit_count", hit_count, 2);
    check("t6_miss_count", miss_count, 1);

    repeat (5) @(negedge clk);
    check("rsp_queue_empty", exp_rsp.size(), 0);
    check("mem_queue_empty", exp_mem.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
